// File: rtl/alu_share_ctrl.sv
// Shared-ALU controller: round-robin arbitration of two requesters onto one
// integer ALU, with a registered per-requester result and response handshake.
module alu_share_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [3:0]      req0_op,
    input  logic [XLEN-1:0] req0_rs1,
    input  logic [XLEN-1:0] req0_rs2,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [3:0]      req1_op,
    input  logic [XLEN-1:0] req1_rs1,
    input  logic [XLEN-1:0] req1_rs2,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_rd,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_rd
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state_q, state_d;
    logic              prio_q, prio_d;
    logic              gnt_q, gnt_d;
    logic [3:0]        op_q, op_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [XLEN-1:0]   rs2_q, rs2_d;
    logic [XLEN-1:0]   rd0_q, rd0_d;
    logic [XLEN-1:0]   rd1_q, rd1_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic              grant0, grant1;
    logic [XLEN-1:0]   alu_res;

    function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [SHW-1:0] shamt;
        shamt = b[SHW-1:0];
        case (op)
            4'd0:    alu_f = a + b;
            4'd1:    alu_f = a - b;
            4'd2:    alu_f = a ^ b;
            4'd3:    alu_f = a | b;
            4'd4:    alu_f = a & b;
            4'd5:    alu_f = a << shamt;
            4'd6:    alu_f = a >> shamt;
            4'd7:    alu_f = $unsigned($signed(a) >>> shamt);
            4'd8:    alu_f = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd9:    alu_f = {{(XLEN-1){1'b0}}, (a < b)};
            default: alu_f = '0;
        endcase
    endfunction

    // Round-robin: the pointer only breaks ties when both requesters are valid.
    assign grant0 = req0_valid & (~req1_valid | (prio_q == 1'b0));
    assign grant1 = req1_valid & (~req0_valid | (prio_q == 1'b1));

    assign req0_ready = (state_q == IDLE) & grant0;
    assign req1_ready = (state_q == IDLE) & grant1;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rd    = rd0_q;
    assign rsp1_rd    = rd1_q;
    assign alu_res    = alu_f(op_q, rs1_q, rs2_q);

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        gnt_d        = gnt_q;
        op_d         = op_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd0_d        = rd0_q;
        rd1_d        = rd1_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        case (state_q)
            IDLE: begin
                if (grant0 | grant1) begin
                    gnt_d   = grant1;
                    op_d    = grant1 ? req1_op  : req0_op;
                    rs1_d   = grant1 ? req1_rs1 : req0_rs1;
                    rs2_d   = grant1 ? req1_rs2 : req0_rs2;
                    prio_d  = ~grant1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (gnt_q) begin
                    rd1_d        = alu_res;
                    rsp1_valid_d = 1'b1;
                end else begin
                    rd0_d        = alu_res;
                    rsp0_valid_d = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                // Only the grantee's ready can complete the response.
                if ((~gnt_q & rsp0_ready) | (gnt_q & rsp1_ready)) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                rsp0_valid_d = 1'b0;
                rsp1_valid_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            prio_q       <= 1'b0;
            gnt_q        <= 1'b0;
            op_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd0_q        <= '0;
            rd1_q        <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            gnt_q        <= gnt_d;
            op_q         <= op_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd0_q        <= rd0_d;
            rd1_q        <= rd1_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: vector table of single transactions plus
// hand-written alternation, back-pressure and mid-operation reset sequences.
module tb_alu_share_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_rs1 = '0, req0_rs2 = '0, req1_rs1 = '0, req1_rs2 = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [31:0] rsp0_rd, rsp1_rd;

    int n_total = 0;
    int n_pass  = 0;

    alu_share_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rd(rsp0_rd),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rd(rsp1_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            req1_valid = v; req1_op = op; req1_rs1 = a; req1_rs2 = b;
        end else begin
            req0_valid = v; req0_op = op; req0_rs1 = a; req0_rs2 = b;
        end
    endtask

    // One isolated transaction on requester v.id, with the response taken at once.
    task automatic run_vec(input vec_t v, input int k);
        logic [31:0] other_rd;
        other_rd = v.id ? rsp0_rd : rsp1_rd;
        set_req(v.id, 1'b1, v.op, v.a, v.b);
        #1;
        check($sformatf("v%0d ready", k), v.id ? req1_ready : req0_ready, 1);
        check($sformatf("v%0d other_ready", k), v.id ? req0_ready : req1_ready, 0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        check($sformatf("v%0d exec_no_rsp", k), {rsp1_valid, rsp0_valid}, 0);
        step();
        check($sformatf("v%0d rsp_valid", k), {rsp1_valid, rsp0_valid}, v.id ? 2 : 1);
        check($sformatf("v%0d rd", k), v.id ? rsp1_rd : rsp0_rd, v.exp);
        check($sformatf("v%0d other_rd_hold", k), v.id ? rsp0_rd : rsp1_rd, other_rd);
        step();
        check($sformatf("v%0d rsp_done", k), {rsp1_valid, rsp0_valid}, 0);
    endtask

    vec_t vecs[12];
    vec_t alt0[4];
    vec_t alt1[4];

    initial begin
        vecs[0]  = '{1'b0, 4'd2,  32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[1]  = '{1'b0, 4'd2,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[2]  = '{1'b1, 4'd7,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
        vecs[3]  = '{1'b0, 4'd6,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
        vecs[4]  = '{1'b1, 4'd5,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002};
        vecs[5]  = '{1'b0, 4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[6]  = '{1'b1, 4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[7]  = '{1'b0, 4'd1,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
        vecs[8]  = '{1'b1, 4'd12, 32'h0000_1234, 32'h0000_5678, 32'h0000_0000};
        vecs[9]  = '{1'b0, 4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
        vecs[10] = '{1'b1, 4'd3,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F};
        vecs[11] = '{1'b0, 4'd4,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00};

        alt0[0] = '{1'b0, 4'd0, 32'd5,          32'd7,          32'd12};
        alt0[1] = '{1'b0, 4'd1, 32'd10,         32'd3,          32'd7};
        alt0[2] = '{1'b0, 4'd2, 32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555};
        alt0[3] = '{1'b0, 4'd9, 32'd1,          32'd2,          32'd1};
        alt1[0] = '{1'b1, 4'd0, 32'hFFFF_FFFF,  32'd1,          32'd0};
        alt1[1] = '{1'b1, 4'd3, 32'h0000_000F,  32'h0000_00F0,  32'h0000_00FF};
        alt1[2] = '{1'b1, 4'd7, 32'hF000_0000,  32'h0000_0024,  32'hFF00_0000};
        alt1[3] = '{1'b1, 4'd4, 32'h0000_FFFF,  32'h0000_0FF0,  32'h0000_0FF0};

        // Reset state
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #12;
        check("rst rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        check("rst rsp0_rd", rsp0_rd, 0);
        check("rst rsp1_rd", rsp1_rd, 0);
        check("rst ready", {req1_ready, req0_ready}, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Alternation with both requesters held valid, starting from reset prio.
        rst_n = 1'b0; #2; rst_n = 1'b1;
        step();
        set_req(1'b0, 1'b1, alt0[0].op, alt0[0].a, alt0[0].b);
        set_req(1'b1, 1'b1, alt1[0].op, alt1[0].a, alt1[0].b);
        for (int k = 0; k < 8; k++) begin
            int   idx;
            logic g;
            vec_t cur;
            g   = k[0];
            idx = k / 2;
            cur = g ? alt1[idx] : alt0[idx];
            #1;
            check($sformatf("alt%0d grant", k), {req1_ready, req0_ready}, g ? 2 : 1);
            step();
            if (idx < 3) begin
                if (g) set_req(1'b1, 1'b1, alt1[idx+1].op, alt1[idx+1].a, alt1[idx+1].b);
                else   set_req(1'b0, 1'b1, alt0[idx+1].op, alt0[idx+1].a, alt0[idx+1].b);
            end else begin
                if (g) req1_valid = 1'b0;
                else   req0_valid = 1'b0;
            end
            step();
            check($sformatf("alt%0d rsp_valid", k), {rsp1_valid, rsp0_valid}, g ? 2 : 1);
            check($sformatf("alt%0d rd", k), g ? rsp1_rd : rsp0_rd, cur.exp);
            check($sformatf("alt%0d busy_ready", k), {req1_ready, req0_ready}, 0);
            step();
        end

        // Back-pressure on requester 0 while requester 1 waits.
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        set_req(1'b0, 1'b1, 4'd2, 32'h1234_5678, 32'hFFFF_0000);
        set_req(1'b1, 1'b1, 4'd0, 32'd2, 32'd3);
        #1;
        check("stall grant0", {req1_ready, req0_ready}, 1);
        step();
        req0_valid = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("stall%0d rsp0_valid", c), {rsp1_valid, rsp0_valid}, 1);
            check($sformatf("stall%0d rsp0_rd", c), rsp0_rd, 32'hEDCB_5678);
            check($sformatf("stall%0d req1_ready", c), req1_ready, 0);
            step();
        end
        rsp0_ready = 1'b1;
        step();
        check("stall release rsp0_valid", rsp0_valid, 0);
        check("stall req1_ready", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        step();
        check("stall rsp1_valid", {rsp1_valid, rsp0_valid}, 2);
        check("stall rsp1_rd", rsp1_rd, 32'd5);
        check("stall rsp0_rd hold", rsp0_rd, 32'hEDCB_5678);
        step();

        // Reset during EXEC after a requester-0 grant moved prio to 1.
        set_req(1'b0, 1'b1, 4'd0, 32'd1, 32'd1);
        #1;
        check("rexec ready0", req0_ready, 1);
        step();
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rexec rsp_valid", {rsp1_valid, rsp0_valid}, 0);
        check("rexec rsp0_rd", rsp0_rd, 0);
        check("rexec rsp1_rd", rsp1_rd, 0);
        rst_n = 1'b1;
        step();
        check("rexec no_rsp", {rsp1_valid, rsp0_valid}, 0);
        step();
        check("rexec no_rsp2", {rsp1_valid, rsp0_valid}, 0);
        set_req(1'b0, 1'b1, 4'd0, 32'd3, 32'd4);
        set_req(1'b1, 1'b1, 4'd1, 32'd9, 32'd4);
        #1;
        check("rexec prio0 grant", {req1_ready, req0_ready}, 1);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        check("rexec rsp0_valid", {rsp1_valid, rsp0_valid}, 1);
        check("rexec rsp0_rd", rsp0_rd, 32'd7);
        step();
        check("rexec idle", {rsp1_valid, rsp0_valid}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
